ysyx_24080006_mdu_ctrl: RTL and testbench
=========================================

# ysyx_24080006_mdu_ctrl

Multi-cycle RV32M sequencer for the execute stage. It accepts one MUL/MULH/DIV/REM request at a time. It computes the result iteratively by borrowing the shared ALU adder through `mdu2alu_t`/`alu2mdu_t` and holds the 32-bit result until writeback takes it. It owns operand extension, sign fix-up and the RISC-V divide-by-zero and overflow corner cases.

## Interface
Parameters:
- none; widths come from `ysyx_24080006_pkg`.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `valid_i` in 1: request valid.
- `ready_o` out 1: controller idle, can accept.
- `mdu_set_i` in `mdu_set_t`: `mdu_enable`, `signed_a`, `signed_b`, `mdu_op`.
- `rs1_i`, `rs2_i` in 32: operands A and B.
- `flush_i` in 1: abort the current operation.
- `alu_req_o` out 1: controller drives the ALU adder this cycle.
- `mdu2alu_o` out `mdu2alu_t`: 33-bit adder operands a and b.
- `alu2mdu_i` in `alu2mdu_t`: `res_34` is the combinational sign-extended a+b (34 bits). `res_32` and `not_zero` are ignored.
- `valid_o` out 1: result valid.
- `result_o` out 32: result.
- `ready_i` in 1: consumer takes the result.
- `busy_o` out 1: the state is not IDLE.

## Operation
- Accept on `valid_i & mdu_enable & ready_o`.
  - Operands are extended to 33 bits per `signed_a`/`signed_b`.
  - The op is latched.
- States: IDLE → PREP → CALC → (FIXUP) → DONE → IDLE.
- MUL (MULL, MULH): 33×33 shift-add.
  - PREP (1 cycle): compute −B (ALU a=~B, b=1) and store it.
  - CALC (33 cycles), iteration i=0..32: if multiplier bit i = 1, acc_hi += B. For i=32 use −B instead.
  - After each iteration, {acc_hi, mplier} shifts right 1 arithmetically.
  - MULL returns the low 32 bits of the 66-bit product; MULH returns bits 63:32.
- DIV (DIV, REM):
  - When `signed_b` is set, A and B are treated as signed.
  - PREP cycle 1: store |A| (negate via ALU if negative).
  - PREP cycle 2: store −|B|.
  - CALC (32 cycles), restoring division: trial = {rem,next dividend bit} + (−|B|). If `res_34` ≥ 0, keep the trial and set the quotient bit to 1; otherwise restore and set it to 0.
  - FIXUP (1 cycle): DIV negates q when sign(A)≠sign(B); REM negates r when A<0. In every other case FIXUP passes the value through.
- Divide by zero (B==0, detected at accept): skip straight to DONE. DIV returns 0xFFFFFFFF; REM returns A.
- Signed overflow (0x80000000 / −1) falls out naturally: q=0x80000000, r=0. It needs no special path.
- `alu_req_o` is high exactly in PREP, CALC and FIXUP.
- `mdu2alu_o` is 0 whenever `alu_req_o` is low.
- `flush_i` in any state forces IDLE at the next edge.
  - `valid_o` drops with no result.
  - `flush_i` together with `valid_i` in IDLE: flush wins and the request is not accepted.
- A request with `mdu_enable`=0 is ignored.

## Timing
- Reset values:
  - state = IDLE, `ready_o`=1.
  - `valid_o`=0, `result_o`=0, `alu_req_o`=0, `busy_o`=0.
  - All accumulators are 0.
- Counting from the accept edge as cycle 0:
  - MUL: PREP is cycle 1, CALC is cycles 2–34, DONE is at cycle 35.
  - DIV: PREP is cycles 1–2, CALC is cycles 3–34, FIXUP is cycle 35, DONE is at cycle 36.
  - Divide by zero: DONE at cycle 1.
- DONE holds `valid_o`/`result_o` stable until `valid_o & ready_i`, then returns to IDLE on the next edge.
- `ready_o` is low while in DONE, so there is no back-to-back accept in the same cycle.
- The ALU result is consumed in the same cycle it is requested; there is no ALU wait state.
- The iteration counter is 6 bits, loaded at PREP exit and decremented in CALC. CALC exits when the counter reaches 0.

## Structure
- Package `ysyx_24080006_pkg` gains:
  - `mdu_state_e` {IDLE, PREP, CALC, FIXUP, DONE}.
  - Constants `MUL_ITER=33` and `DIV_ITER=32`.
  - It reuses `mdu_set_t`, `mdu_op_e`, `mdu2alu_t` and `alu2mdu_t`.
- The block is a single module with no sub-module.
- The ALU side of the shared adder, and EX-stage stalling on `busy_o`, live in the existing ALU/EX logic.

## Test plan
- MULL 7×(−3), signed_a=signed_b=1 → `result_o`=0xFFFFFFEB; `valid_o` rises exactly at cycle 35.
- MULH (signed) 0x80000000×0x80000000 → 0x40000000. MULHU (unsigned) 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF. `valid_o` rises at cycle 36.
- DIV x/0 → 0xFFFFFFFF; REM 5/0 → 5; `valid_o` rises at cycle 1. DIV 0x80000000/−1 → 0x80000000; REM gives 0.
- `ready_i`=0 for 10 cycles in DONE → result held stable and `ready_o`=0. Then `ready_i`=1 → IDLE next cycle.
- `flush_i` at CALC cycle 10 → IDLE next cycle, no `valid_o`. Asserting `reset` mid-DIV → all outputs reach their reset values immediately, asynchronously.

Source files
------------

// File: rtl/ysyx_24080006_pkg.sv
// Shared execute-stage types for the ysyx_24080006 core.
// Covers the MDU request bundle, the shared-adder handshake and MDU sequencing.
package ysyx_24080006_pkg;

   typedef enum logic [1:0] {
      MDU_MUL,
      MDU_MULH,
      MDU_DIV,
      MDU_REM
   } mdu_op_e;

   typedef struct packed {
      logic    mdu_enable;
      logic    signed_a;
      logic    signed_b;
      mdu_op_e mdu_op;
   } mdu_set_t;

   typedef struct packed {
      logic [32:0] a;
      logic [32:0] b;
   } mdu2alu_t;

   typedef struct packed {
      logic [33:0] res_34;
      logic [31:0] res_32;
      logic        not_zero;
   } alu2mdu_t;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIXUP,
      DONE
   } mdu_state_e;

   localparam logic [5:0] MUL_ITER = 6'd33;
   localparam logic [5:0] DIV_ITER = 6'd32;

endpackage

// File: rtl/ysyx_24080006_mdu_ctrl.sv
// Iterative RV32M multiply/divide sequencer.
// Borrows the shared ALU adder for every add/negate step.
module ysyx_24080006_mdu_ctrl
   import ysyx_24080006_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        valid_i,
   output logic        ready_o,
   input  mdu_set_t    mdu_set_i,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   input  logic        flush_i,
   output logic        alu_req_o,
   output mdu2alu_t    mdu2alu_o,
   input  alu2mdu_t    alu2mdu_i,
   output logic        valid_o,
   output logic [31:0] result_o,
   input  logic        ready_i,
   output logic        busy_o
);

   localparam logic [2:0] S_IDLE  = 3'(IDLE);
   localparam logic [2:0] S_PREP  = 3'(PREP);
   localparam logic [2:0] S_CALC  = 3'(CALC);
   localparam logic [2:0] S_FIXUP = 3'(FIXUP);
   localparam logic [2:0] S_DONE  = 3'(DONE);

   logic [2:0]  state;
   mdu_op_e     op;
   logic [32:0] acc;
   logic [32:0] mq;
   logic [32:0] opb;
   logic [32:0] negb;
   logic [5:0]  cnt;
   logic        prep2;
   logic        neg_a;
   logic        neg_b;
   logic [31:0] result;

   logic [32:0] alu_a;
   logic [32:0] alu_b;
   logic [33:0] sum;
   logic [32:0] nxt_acc;
   logic [32:0] nxt_mq;
   logic        keep;
   logic        fix_neg;
   logic [31:0] fix_val;
   logic        is_div;
   logic        last;
   logic        accept;
   logic        div_zero;
   logic        unused_alu;

   assign sum      = alu2mdu_i.res_34;
   assign is_div   = op[1];
   assign last     = (cnt == 6'd1);
   assign accept   = valid_i & mdu_set_i.mdu_enable & ready_o & ~flush_i;
   assign div_zero = mdu_set_i.mdu_op[1] & (rs2_i == 32'd0);

   assign unused_alu = ^{alu2mdu_i.res_32, alu2mdu_i.not_zero};

   assign ready_o   = (state == S_IDLE);
   assign busy_o    = (state != S_IDLE);
   assign valid_o   = (state == S_DONE);
   assign result_o  = result;
   assign alu_req_o = (state == S_PREP) | (state == S_CALC) | (state == S_FIXUP);
   assign mdu2alu_o = alu_req_o ? '{a: alu_a, b: alu_b} : '0;

   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      keep    = 1'b0;
      nxt_acc = acc;
      nxt_mq  = mq;
      fix_neg = 1'b0;
      fix_val = '0;
      case (state)
         S_PREP: begin
            if (!is_div) begin
               alu_a = ~opb;
               alu_b = 33'd1;
            end else if (!prep2) begin
               alu_a = neg_a ? ~mq : mq;
               alu_b = {32'd0, neg_a};
            end else begin
               alu_a = neg_b ? opb : ~opb;
               alu_b = {32'd0, ~neg_b};
            end
         end
         S_CALC: begin
            if (!is_div) begin
               alu_a   = acc;
               alu_b   = mq[0] ? (last ? negb : opb) : '0;
               nxt_acc = sum[33:1];
               nxt_mq  = {sum[0], mq[32:1]};
            end else begin
               alu_a   = {acc[31:0], mq[31]};
               alu_b   = negb;
               // A set top bit means the shifted remainder already exceeds any divisor
               keep    = ~sum[33] | acc[31];
               nxt_acc = keep ? {1'b0, sum[31:0]} : {1'b0, acc[30:0], mq[31]};
               nxt_mq  = {1'b0, mq[30:0], keep};
            end
         end
         S_FIXUP: begin
            fix_neg = (op == MDU_DIV) ? (neg_a ^ neg_b) : neg_a;
            fix_val = (op == MDU_DIV) ? mq[31:0] : acc[31:0];
            alu_a   = fix_neg ? ~{1'b0, fix_val} : {1'b0, fix_val};
            alu_b   = {32'd0, fix_neg};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         op     <= MDU_MUL;
         acc    <= '0;
         mq     <= '0;
         opb    <= '0;
         negb   <= '0;
         cnt    <= '0;
         prep2  <= 1'b0;
         neg_a  <= 1'b0;
         neg_b  <= 1'b0;
         result <= '0;
      end else if (flush_i) begin
         state  <= S_IDLE;
         result <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op    <= mdu_set_i.mdu_op;
                  mq    <= {mdu_set_i.signed_a & rs1_i[31], rs1_i};
                  opb   <= {mdu_set_i.signed_b & rs2_i[31], rs2_i};
                  acc   <= '0;
                  prep2 <= 1'b0;
                  neg_a <= mdu_set_i.signed_b & rs1_i[31];
                  neg_b <= mdu_set_i.signed_b & rs2_i[31];
                  if (div_zero) begin
                     result <= (mdu_set_i.mdu_op == MDU_DIV) ? 32'hFFFF_FFFF : rs1_i;
                     state  <= S_DONE;
                  end else begin
                     state  <= S_PREP;
                  end
               end
            end
            S_PREP: begin
               if (is_div && !prep2) begin
                  mq    <= {1'b0, sum[31:0]};
                  prep2 <= 1'b1;
               end else begin
                  negb  <= sum[32:0];
                  cnt   <= is_div ? DIV_ITER : MUL_ITER;
                  acc   <= '0;
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               acc <= nxt_acc;
               mq  <= nxt_mq;
               cnt <= cnt - 6'd1;
               if (last) begin
                  if (is_div) begin
                     state <= S_FIXUP;
                  end else begin
                     result <= (op == MDU_MULH) ? {nxt_acc[30:0], nxt_mq[32]}
                                                : nxt_mq[31:0];
                     state  <= S_DONE;
                  end
               end
            end
            S_FIXUP: begin
               result <= sum[31:0];
               state  <= S_DONE;
            end
            S_DONE: begin
               if (ready_i) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_24080006_mdu_ctrl.sv
// Self-checking bench for the RV32M sequencer: directed table,
// random operands against an arithmetic model, and control corner cases.
module tb_ysyx_24080006_mdu_ctrl;
   import ysyx_24080006_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        valid_i;
   logic        ready_o;
   mdu_set_t    mdu_set_i;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic        flush_i;
   logic        alu_req_o;
   mdu2alu_t    mdu2alu_o;
   alu2mdu_t    alu2mdu_i;
   logic        valid_o;
   logic [31:0] result_o;
   logic        ready_i;
   logic        busy_o;

   logic [33:0] alu_sum;

   int nvec = 0;
   int nmis = 0;

   always #5 clock = ~clock;

   // Stand-in for the shared ALU adder
   assign alu_sum   = {mdu2alu_o.a[32], mdu2alu_o.a} + {mdu2alu_o.b[32], mdu2alu_o.b};
   assign alu2mdu_i = '{res_34: alu_sum, res_32: alu_sum[31:0], not_zero: |alu_sum[31:0]};

   ysyx_24080006_mdu_ctrl dut (
      .clock     (clock),
      .reset     (reset),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .mdu_set_i (mdu_set_i),
      .rs1_i     (rs1_i),
      .rs2_i     (rs2_i),
      .flush_i   (flush_i),
      .alu_req_o (alu_req_o),
      .mdu2alu_o (mdu2alu_o),
      .alu2mdu_i (alu2mdu_i),
      .valid_o   (valid_o),
      .result_o  (result_o),
      .ready_i   (ready_i),
      .busy_o    (busy_o)
   );

   typedef struct {
      mdu_op_e     op;
      bit          sa;
      bit          sb;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input mdu_op_e op, input bit sa, input bit sb,
                                         input logic [31:0] a, input logic [31:0] b);
      longint xa;
      longint xb;
      longint p;
      if (op == MDU_MUL || op == MDU_MULH) begin
         xa = sa ? longint'($signed(a)) : longint'({32'd0, a});
         xb = sb ? longint'($signed(b)) : longint'({32'd0, b});
         p  = xa * xb;
         return (op == MDU_MUL) ? p[31:0] : p[63:32];
      end
      if (b == 32'd0) return (op == MDU_DIV) ? 32'hFFFF_FFFF : a;
      xa = sb ? longint'($signed(a)) : longint'({32'd0, a});
      xb = sb ? longint'($signed(b)) : longint'({32'd0, b});
      p  = (op == MDU_DIV) ? xa / xb : xa % xb;
      return p[31:0];
   endfunction

   function automatic int lat_of(input mdu_op_e op, input logic [31:0] b);
      if (op == MDU_MUL || op == MDU_MULH) return 35;
      return (b == 32'd0) ? 1 : 36;
   endfunction

   function automatic int alu_of(input mdu_op_e op, input logic [31:0] b);
      if (op == MDU_MUL || op == MDU_MULH) return 34;
      return (b == 32'd0) ? 0 : 35;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 9))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Issue one request and wait (bounded) for the result
   task automatic run_op(input mdu_op_e op, input bit sa, input bit sb,
                         input logic [31:0] a, input logic [31:0] b, input bit rdy,
                         output logic [31:0] res, output int lat,
                         output int alu, output bit zok);
      @(negedge clock);
      mdu_set_i = '{mdu_enable: 1'b1, signed_a: sa, signed_b: sb, mdu_op: op};
      rs1_i   = a;
      rs2_i   = b;
      ready_i = rdy;
      valid_i = 1'b1;
      @(negedge clock);
      valid_i = 1'b0;
      lat = 1;
      alu = 0;
      zok = 1'b1;
      while (!valid_o && lat < 100) begin
         if (alu_req_o) alu++;
         else if (mdu2alu_o != '0) zok = 1'b0;
         @(negedge clock);
         lat++;
      end
      res = result_o;
   endtask

   vec_t        tv[16];
   logic [31:0] res;
   logic [31:0] held;
   int          lat;
   int          alu;
   bit          zok;
   bit          ok;
   mdu_op_e     rop;
   bit          rsa;
   bit          rsb;
   logic [31:0] ra;
   logic [31:0] rb;

   initial begin
      tv[0]  = '{MDU_MUL,  1, 1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
      tv[1]  = '{MDU_MULH, 1, 1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
      tv[2]  = '{MDU_MULH, 0, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
      tv[3]  = '{MDU_DIV,  1, 1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
      tv[4]  = '{MDU_REM,  1, 1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
      tv[5]  = '{MDU_DIV,  0, 0, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF};
      tv[6]  = '{MDU_DIV,  1, 1, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF};
      tv[7]  = '{MDU_REM,  1, 1, 32'd5,          32'd0,         32'd5};
      tv[8]  = '{MDU_DIV,  1, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
      tv[9]  = '{MDU_REM,  1, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
      tv[10] = '{MDU_REM,  0, 0, 32'hFFFF_FFFF,  32'h8000_0001, 32'h7FFF_FFFE};
      tv[11] = '{MDU_DIV,  0, 0, 32'hFFFF_FFFF,  32'h8000_0001, 32'd1};
      tv[12] = '{MDU_MULH, 1, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
      tv[13] = '{MDU_MUL,  0, 0, 32'd0,          32'd5,         32'd0};
      tv[14] = '{MDU_REM,  0, 0, 32'd100,        32'd7,         32'd2};
      tv[15] = '{MDU_DIV,  1, 1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2};

      reset     = 1'b1;
      valid_i   = 1'b0;
      flush_i   = 1'b0;
      ready_i   = 1'b1;
      mdu_set_i = '0;
      rs1_i     = '0;
      rs2_i     = '0;
      #2;
      chk("rst_ready", ready_o, 1);
      chk("rst_valid", valid_o, 0);
      chk("rst_result", result_o, 0);
      chk("rst_alureq", alu_req_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_mdu2alu_zero", mdu2alu_o == '0, 1);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         run_op(tv[i].op, tv[i].sa, tv[i].sb, tv[i].a, tv[i].b, 1'b1, res, lat, alu, zok);
         chk($sformatf("vec%0d_result", i), res, tv[i].exp);
         chk($sformatf("vec%0d_latency", i), lat, lat_of(tv[i].op, tv[i].b));
         chk($sformatf("vec%0d_alu_cycles", i), alu, alu_of(tv[i].op, tv[i].b));
         chk($sformatf("vec%0d_mdu2alu_idle", i), zok, 1);
      end

      for (int i = 0; i < 150; i++) begin
         rop = mdu_op_e'($urandom_range(0, 3));
         rsa = 1'($urandom_range(0, 1));
         rsb = (rop == MDU_DIV || rop == MDU_REM) ? rsa : 1'($urandom_range(0, 1));
         ra  = pick();
         rb  = pick();
         run_op(rop, rsa, rsb, ra, rb, 1'b1, res, lat, alu, zok);
         chk($sformatf("rnd%0d_op%0d_%0h_%0h", i, rop, ra, rb), res, model(rop, rsa, rsb, ra, rb));
         chk($sformatf("rnd%0d_latency", i), lat, lat_of(rop, rb));
      end

      // Result held while writeback stalls
      run_op(MDU_DIV, 0, 0, 32'd100, 32'd7, 1'b0, res, lat, alu, zok);
      chk("hold_result", res, 32'd14);
      held = result_o;
      ok = 1'b1;
      repeat (10) begin
         @(negedge clock);
         if (!valid_o || result_o !== held || ready_o) ok = 1'b0;
      end
      chk("hold_stable", ok, 1);
      ready_i = 1'b1;
      @(negedge clock);
      chk("hold_release_ready", ready_o, 1);
      chk("hold_release_busy", busy_o, 0);

      // Flush in the middle of CALC
      mdu_set_i = '{mdu_enable: 1'b1, signed_a: 1'b1, signed_b: 1'b1, mdu_op: MDU_MUL};
      rs1_i   = 32'd123;
      rs2_i   = 32'd456;
      valid_i = 1'b1;
      @(negedge clock);
      valid_i = 1'b0;
      repeat (10) @(negedge clock);
      chk("flush_pre_busy", busy_o, 1);
      flush_i = 1'b1;
      @(negedge clock);
      flush_i = 1'b0;
      chk("flush_idle", ready_o, 1);
      chk("flush_alureq", alu_req_o, 0);
      ok = 1'b1;
      repeat (40) begin
         if (valid_o || busy_o) ok = 1'b0;
         @(negedge clock);
      end
      chk("flush_no_valid", ok, 1);

      // Flush beats a simultaneous request
      valid_i = 1'b1;
      flush_i = 1'b1;
      @(negedge clock);
      valid_i = 1'b0;
      flush_i = 1'b0;
      chk("flush_vs_valid", busy_o, 0);

      // Disabled request is ignored
      mdu_set_i.mdu_enable = 1'b0;
      valid_i = 1'b1;
      @(negedge clock);
      valid_i = 1'b0;
      chk("enable_off", busy_o, 0);

      // Asynchronous reset during a divide
      mdu_set_i = '{mdu_enable: 1'b1, signed_a: 1'b1, signed_b: 1'b1, mdu_op: MDU_DIV};
      rs1_i   = 32'd1000;
      rs2_i   = 32'd3;
      valid_i = 1'b1;
      @(negedge clock);
      valid_i = 1'b0;
      repeat (20) @(negedge clock);
      chk("mid_div_busy", busy_o, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_ready", ready_o, 1);
      chk("async_rst_busy", busy_o, 0);
      chk("async_rst_alureq", alu_req_o, 0);
      chk("async_rst_valid", valid_o, 0);
      chk("async_rst_result", result_o, 0);
      chk("async_rst_mdu2alu", mdu2alu_o == '0, 1);
      @(negedge clock);
      reset = 1'b0;

      run_op(MDU_REM, 1, 1, 32'd1000, 32'd3, 1'b1, res, lat, alu, zok);
      chk("post_rst_rem", res, 32'd1);
      chk("post_rst_latency", lat, 36);

      @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
